// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM controller request port between a
// high-priority fetch port (port 0) and the CPU bus (port 1). Only one
// transaction is in flight at a time. Port 0 normally wins. A run counter
// hands the port to the CPU after MAX_P0_RUN back-to-back port-0 grants made
// while the CPU was waiting.
`timescale 1ns/1ps

module sdram_arbiter #(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 32,
  parameter int MAX_P0_RUN = 4
) (
  input  logic                  clk,
  input  logic                  reset_i,
  // port 0: video/audio fetch
  input  logic                  p0_req_i,
  input  logic                  p0_we_i,
  input  logic [ADDR_W-1:0]     p0_addr_i,
  input  logic [DATA_W-1:0]     p0_wdata_i,
  input  logic [DATA_W/8-1:0]   p0_wmask_i,
  output logic                  p0_ack_o,
  output logic [DATA_W-1:0]     p0_rdata_o,
  // port 1: CPU bus
  input  logic                  p1_req_i,
  input  logic                  p1_we_i,
  input  logic [ADDR_W-1:0]     p1_addr_i,
  input  logic [DATA_W-1:0]     p1_wdata_i,
  input  logic [DATA_W/8-1:0]   p1_wmask_i,
  output logic                  p1_ack_o,
  output logic [DATA_W-1:0]     p1_rdata_o,
  // SDRAM controller side
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  output logic [DATA_W/8-1:0]   mem_wmask_o,
  input  logic                  mem_ack_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_W-1:0]     mem_rdata_i
);

  localparam int         MASK_W  = DATA_W / 8;
  localparam logic [3:0] RUN_MAX = 4'(MAX_P0_RUN);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RDWAIT,
    ST_DONE
  } state_t;

  state_t              state_q;
  logic                owner_q;
  logic [3:0]          run_q;
  logic [3:0]          run_d;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [MASK_W-1:0]   mem_wmask_q;
  logic                p0_ack_q;
  logic                p1_ack_q;
  logic [DATA_W-1:0]   p0_rdata_q;
  logic [DATA_W-1:0]   p1_rdata_q;

  logic                ack_gap;
  logic                grant_p0;
  logic                grant_p1;

  // Grant decision and next run count, evaluated only in IDLE. A write ack is
  // visible during the first IDLE cycle after DONE; that cycle grants nothing
  // so the acknowledged requester has time to drop or replace its request.
  always_comb begin
    ack_gap  = p0_ack_q | p1_ack_q;
    grant_p0 = 1'b0;
    grant_p1 = 1'b0;
    run_d    = run_q;
    if (state_q == ST_IDLE && !ack_gap) begin
      if (p1_req_i && (!p0_req_i || run_q == RUN_MAX)) begin
        grant_p1 = 1'b1;
        run_d    = '0;
      end else if (p0_req_i) begin
        grant_p0 = 1'b1;
        if (!p1_req_i) begin
          run_d = '0;
        end else if (run_q != RUN_MAX) begin
          run_d = run_q + 4'd1;
        end
      end
    end
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      run_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      p0_ack_q    <= 1'b0;
      p1_ack_q    <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
    end else begin
      p0_ack_q <= 1'b0;
      p1_ack_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (grant_p1) begin
            owner_q     <= 1'b1;
            run_q       <= run_d;
            mem_req_q   <= 1'b1;
            mem_we_q    <= p1_we_i;
            mem_addr_q  <= p1_addr_i;
            mem_wdata_q <= p1_wdata_i;
            mem_wmask_q <= p1_wmask_i;
            state_q     <= ST_ISSUE;
          end else if (grant_p0) begin
            owner_q     <= 1'b0;
            run_q       <= run_d;
            mem_req_q   <= 1'b1;
            mem_we_q    <= p0_we_i;
            mem_addr_q  <= p0_addr_i;
            mem_wdata_q <= p0_wdata_i;
            mem_wmask_q <= p0_wmask_i;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // A simultaneous rvalid here is not data for this command; only the
          // ack is honoured and the read still waits in RDWAIT.
          if (mem_ack_i) begin
            mem_req_q <= 1'b0;
            state_q   <= mem_we_q ? ST_DONE : ST_RDWAIT;
          end
        end
        ST_RDWAIT: begin
          // Read ack is raised together with the data capture so it shows up
          // one cycle after rvalid, while the FSM sits in DONE.
          if (mem_rvalid_i) begin
            if (owner_q) begin
              p1_rdata_q <= mem_rdata_i;
              p1_ack_q   <= 1'b1;
            end else begin
              p0_rdata_q <= mem_rdata_i;
              p0_ack_q   <= 1'b1;
            end
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Writes raise their ack here; it appears in the following IDLE
          // cycle, which is then held as the grant gap.
          if (mem_we_q) begin
            p0_ack_q <= ~owner_q;
            p1_ack_q <= owner_q;
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_wmask_o = mem_wmask_q;
  assign p0_ack_o    = p0_ack_q;
  assign p1_ack_o    = p1_ack_q;
  assign p0_rdata_o  = p0_rdata_q;
  assign p1_rdata_o  = p1_rdata_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Testbench for sdram_arbiter: requester and controller models driven from
// per-port command queues, with a scoreboard of expected grants/acks.
`timescale 1ns/1ps

module tb_sdram_arbiter;

  localparam int ADDR_W     = 24;
  localparam int DATA_W     = 32;
  localparam int MASK_W     = DATA_W / 8;
  localparam int MAX_P0_RUN = 4;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic                reset_i;
  logic                p0_req_i, p0_we_i, p0_ack_o;
  logic [ADDR_W-1:0]   p0_addr_i;
  logic [DATA_W-1:0]   p0_wdata_i, p0_rdata_o;
  logic [MASK_W-1:0]   p0_wmask_i;
  logic                p1_req_i, p1_we_i, p1_ack_o;
  logic [ADDR_W-1:0]   p1_addr_i;
  logic [DATA_W-1:0]   p1_wdata_i, p1_rdata_o;
  logic [MASK_W-1:0]   p1_wmask_i;
  logic                mem_req_o, mem_we_o, mem_ack_i, mem_rvalid_i;
  logic [ADDR_W-1:0]   mem_addr_o;
  logic [DATA_W-1:0]   mem_wdata_o, mem_rdata_i;
  logic [MASK_W-1:0]   mem_wmask_o;

  sdram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_P0_RUN(MAX_P0_RUN)
  ) dut (
    .clk(clk), .reset_i(reset_i),
    .p0_req_i(p0_req_i), .p0_we_i(p0_we_i), .p0_addr_i(p0_addr_i),
    .p0_wdata_i(p0_wdata_i), .p0_wmask_i(p0_wmask_i),
    .p0_ack_o(p0_ack_o), .p0_rdata_o(p0_rdata_o),
    .p1_req_i(p1_req_i), .p1_we_i(p1_we_i), .p1_addr_i(p1_addr_i),
    .p1_wdata_i(p1_wdata_i), .p1_wmask_i(p1_wmask_i),
    .p1_ack_o(p1_ack_o), .p1_rdata_o(p1_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
    .mem_ack_i(mem_ack_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  typedef struct {
    logic              port;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
    logic [DATA_W-1:0] rdata;
  } txn_t;

  txn_t cq0[$];
  txn_t cq1[$];
  txn_t exp_q[$];

  int n_chk = 0;
  int n_err = 0;

  int cyc = 0;
  int r1_cyc = 0, grant_cyc = 0, mack_cyc = 0, rv_cyc = 0, pack_cyc = 0;
  int grant_gap = 0, mreq_len = 0, last_mreq_len = 0;
  logic [15:0] ack_log = '0;
  logic p1_req_prev = 1'b0;
  logic mreq_prev = 1'b0;
  logic [60:0] held;

  // controller model knobs
  int ack_dly = 0;
  int rv_dly  = 1;
  bit rd_force = 1'b0;
  logic [DATA_W-1:0] rd_val = '0;

  function automatic logic [DATA_W-1:0] rd_fn(input logic [ADDR_W-1:0] a);
    return {a[7:0], a} ^ 32'hA5C3_0F69;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void push(input logic port, input logic we,
                               input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                               input logic [MASK_W-1:0] wm);
    txn_t t;
    t.port  = port;
    t.we    = we;
    t.addr  = a;
    t.wdata = wd;
    t.wmask = wm;
    t.rdata = rd_force ? rd_val : rd_fn(a);
    if (port) cq1.push_back(t);
    else      cq0.push_back(t);
    exp_q.push_back(t);
  endfunction

  // Port 0 requester: raise next command; on ack, replace or drop.
  initial begin
    p0_req_i = 0; p0_we_i = 0; p0_addr_i = '0; p0_wdata_i = '0; p0_wmask_i = '0;
    forever begin
      @(negedge clk);
      if (reset_i) p0_req_i = 1'b0;
      else if (!p0_req_i || p0_ack_o) begin
        if (cq0.size() != 0) begin
          txn_t t;
          t = cq0.pop_front();
          p0_we_i = t.we; p0_addr_i = t.addr; p0_wdata_i = t.wdata; p0_wmask_i = t.wmask;
          p0_req_i = 1'b1;
        end else p0_req_i = 1'b0;
      end
    end
  end

  // Port 1 requester.
  initial begin
    p1_req_i = 0; p1_we_i = 0; p1_addr_i = '0; p1_wdata_i = '0; p1_wmask_i = '0;
    forever begin
      @(negedge clk);
      if (reset_i) p1_req_i = 1'b0;
      else if (!p1_req_i || p1_ack_o) begin
        if (cq1.size() != 0) begin
          txn_t t;
          t = cq1.pop_front();
          p1_we_i = t.we; p1_addr_i = t.addr; p1_wdata_i = t.wdata; p1_wmask_i = t.wmask;
          p1_req_i = 1'b1;
        end else p1_req_i = 1'b0;
      end
    end
  end

  // Controller model: ack after ack_dly cycles, rvalid rv_dly cycles after ack.
  initial begin
    mem_ack_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (mem_req_o && !reset_i) begin
        logic              we_l;
        logic [ADDR_W-1:0] a_l;
        repeat (ack_dly) @(negedge clk);
        we_l = mem_we_o;
        a_l  = mem_addr_o;
        mem_ack_i = 1'b1;
        @(negedge clk);
        mem_ack_i = 1'b0;
        if (!we_l) begin
          repeat (rv_dly - 1) @(negedge clk);
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = rd_force ? rd_val : rd_fn(a_l);
          @(negedge clk);
          mem_rvalid_i = 1'b0;
          mem_rdata_i  = '0;
        end
      end
    end
  end

  // Cycle bookkeeping of TB-driven events, sampled on the active edge.
  always @(posedge clk) begin
    if (mem_ack_i) mack_cyc = cyc;
    if (mem_rvalid_i) rv_cyc = cyc;
    if (p1_req_i && !p1_req_prev) r1_cyc = cyc;
    p1_req_prev = p1_req_i;
    cyc = cyc + 1;
  end

  // Monitor: grant fields, field stability under backpressure, ack scoreboard.
  always @(negedge clk) begin
    if (reset_i) begin
      mreq_prev = 1'b0;
    end else begin
      if (mem_req_o) begin
        if (!mreq_prev) begin
          grant_cyc = cyc;
          grant_gap = cyc - pack_cyc;
          mreq_len  = 0;
          held = {mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o};
          check("grant_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0)
            check("grant_fields", {mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o},
                  {exp_q[0].we, exp_q[0].addr, exp_q[0].wdata, exp_q[0].wmask});
        end else begin
          check("req_stable", {mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o}, held);
        end
        mreq_len++;
      end
      if (p0_ack_o || p1_ack_o) begin
        pack_cyc = cyc;
        check("ack_onehot", p0_ack_o & p1_ack_o, 0);
        check("ack_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          txn_t e;
          e = exp_q.pop_front();
          check("ack_port", p1_ack_o, e.port);
          if (!e.we) check("rdata", e.port ? p1_rdata_o : p0_rdata_o, e.rdata);
          ack_log = {ack_log[14:0], p1_ack_o};
          last_mreq_len = mreq_len;
        end
      end
      mreq_prev = mem_req_o;
    end
  end

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || cq0.size() != 0 || cq1.size() != 0) && n < 600) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, exp_q.size() == 0, 1);
    exp_q.delete(); cq0.delete(); cq1.delete();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rel_cyc;
    reset_i = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mem", {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o}, 0);
    check("rst_ack", {p0_ack_o, p1_ack_o}, 0);
    check("rst_rdata", {p0_rdata_o, p1_rdata_o}, 0);
    @(posedge clk); #1 reset_i = 1'b0;
    repeat (2) @(negedge clk);

    // isolated p1 write, controller acks in the first ISSUE cycle
    @(posedge clk); #1;
    ack_dly = 0;
    push(1'b1, 1'b1, 24'h000100, 32'hDEADBEEF, 4'hF);
    drain("t1");
    check("t1_req_lat", grant_cyc - r1_cyc, 1);
    check("t1_ack_lat", pack_cyc - r1_cyc, 3);
    check("t1_mreq_len", last_mreq_len, 1);

    // p0 read: ack after 2 cycles, rvalid 3 cycles later
    @(posedge clk); #1;
    ack_dly = 2; rv_dly = 3; rd_force = 1'b1; rd_val = 32'h12345678;
    push(1'b0, 1'b0, 24'h000040, 32'h0, 4'h0);
    drain("t2");
    rd_force = 1'b0;
    check("t2_ack_dly", mack_cyc - grant_cyc, 2);
    check("t2_ack_lat", pack_cyc - rv_cyc, 1);
    check("t2_rdata_hold", p0_rdata_o, 32'h12345678);

    // simultaneous requests: p0 first, p1 granted right after p0's DONE
    @(posedge clk); #1;
    ack_dly = 1; rv_dly = 1;
    push(1'b0, 1'b0, 24'h000200, 32'h0, 4'h0);
    push(1'b1, 1'b1, 24'h000300, 32'hCAFE0001, 4'h3);
    drain("t3");
    check("t3_order", ack_log[1:0], 2'b01);
    check("t3_grant_gap", grant_gap, 2);

    // starvation guard with MAX_P0_RUN=4
    @(posedge clk); #1;
    ack_dly = 0;
    for (int i = 0; i < 12; i++) begin
      logic pt;
      pt = (i == 4 || i == 9);
      push(pt, 1'b1, 24'(32'h1000 + i), 32'(32'hA0000000 + i), 4'hF);
    end
    drain("t4");
    check("t4_sequence", ack_log[11:0], 12'b0000_1000_0100);

    // backpressure: mem_ack_i withheld 10 cycles
    @(posedge clk); #1;
    ack_dly = 10;
    push(1'b1, 1'b1, 24'hABCDEF, 32'h5A5A_1234, 4'h9);
    drain("t5");
    check("t5_ack_dly", mack_cyc - grant_cyc, 10);
    check("t5_ack_lat", pack_cyc - mack_cyc, 2);
    check("t5_mreq_len", last_mreq_len, 11);

    // random single transactions
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      ack_dly = $urandom_range(3, 0);
      rv_dly  = $urandom_range(4, 1);
      push(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 24'($urandom),
           $urandom, 4'($urandom));
      drain("t6");
    end

    // reset while in RDWAIT; the late rvalid must be ignored
    @(posedge clk); #1;
    ack_dly = 0; rv_dly = 6;
    push(1'b0, 1'b0, 24'h000055, 32'h0, 4'h0);
    n = 0;
    while (!mem_req_o && n < 50) begin @(negedge clk); n++; end
    while (mem_req_o && n < 100) begin @(negedge clk); n++; end
    check("t7_reach_rdwait", n < 100, 1);
    @(posedge clk); #1 reset_i = 1'b1;
    exp_q.delete(); cq0.delete(); cq1.delete();
    @(negedge clk);
    @(negedge clk);
    check("t7_rst_mem", {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o}, 0);
    check("t7_rst_ack", {p0_ack_o, p1_ack_o}, 0);
    check("t7_rst_rdata", {p0_rdata_o, p1_rdata_o}, 0);
    @(posedge clk); #1 reset_i = 1'b0;
    rel_cyc = cyc;
    repeat (12) @(negedge clk);
    check("t7_stray_rv_after_rst", rv_cyc > rel_cyc, 1);
    check("t7_no_ack_rdata", p0_rdata_o, 0);
    check("t7_idle_mreq", mem_req_o, 0);

    // FSM back in IDLE: normal write latency after reset
    @(posedge clk); #1;
    ack_dly = 0;
    push(1'b1, 1'b1, 24'h000777, 32'h0BAD_F00D, 4'h1);
    drain("t8");
    check("t8_ack_lat", pack_cyc - r1_cyc, 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
